// File: rtl/cache_pkg.sv
// Shared encodings for the MESI cache controller: snoop/CPU commands,
// L2 message codes, per-line MESI states and the controller FSM states.
package cache_pkg;

  typedef enum logic [2:0] {
    CMD_READ       = 3'd0,
    CMD_WRITE      = 3'd1,
    CMD_INVALIDATE = 3'd2,
    CMD_CLEAR      = 3'd3,
    CMD_DATAREQ    = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    L2_RETURNDATA = 2'd0,
    L2_WRITE      = 2'd1,
    L2_READ       = 2'd2,
    L2_RFO        = 2'd3
  } l2_cmd_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_M = 2'd1,
    MESI_S = 2'd2,
    MESI_E = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EVICT,
    S_FILL,
    S_RESP,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/mesi_cache_ctrl_if.sv
// Command/response and L2 message bundle between a requester and the cache
// controller; the requester holds the master side.
interface mesi_cache_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              l2_valid;
  logic [1:0]        l2_cmd;
  logic [ADDR_W-1:0] l2_addr;

  modport master (
    output cmd_valid, cmd, addr,
    input  cmd_ready, resp_valid, resp_hit, l2_valid, l2_cmd, l2_addr
  );

  modport slave (
    input  cmd_valid, cmd, addr,
    output cmd_ready, resp_valid, resp_hit, l2_valid, l2_cmd, l2_addr
  );
endinterface

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: chooses the victim way and computes the tree
// bits after an access. Node n has children 2n+1/2n+2; a 0 bit sends the victim left.
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [$clog2(WAYS)-1:0] i_access_way,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic [WAYS-2:0]         o_bits_next
);
  localparam int WAY_W = $clog2(WAYS);

  // Level l holds nodes (2**l)-1 .. 2*(2**l)-2; the way prefix above level l picks one.
  always_comb begin
    logic [WAY_W-1:0] vic;
    vic = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < (1 << l); n++) begin
        if ((vic >> (WAY_W - l)) == WAY_W'(n)) begin
          vic[WAY_W-1-l] = i_bits[(1 << l) - 1 + n];
        end
      end
    end
    o_victim = vic;
  end

  always_comb begin
    o_bits_next = i_bits;
    for (int l = 0; l < WAY_W; l++) begin
      for (int n = 0; n < (1 << l); n++) begin
        if ((i_access_way >> (WAY_W - l)) == WAY_W'(n)) begin
          o_bits_next[(1 << l) - 1 + n] = ~i_access_way[WAY_W-1-l];
        end
      end
    end
  end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Set-associative MESI cache tag controller: serves READ/WRITE/snoop commands,
// emits L2 messages for evictions, fills and snoop data, and keeps hit/miss stats.
module mesi_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int SET_W    = 4,
  parameter int WAYS     = 4,
  parameter int CNT_W    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  mesi_cache_ctrl_if.slave                   bus,
  input  logic [SET_W-1:0]                   i_dbg_set,
  input  logic [$clog2(WAYS)-1:0]            i_dbg_way,
  output logic [ADDR_W-OFFSET_W-SET_W-1:0]   o_dbg_tag,
  output logic [1:0]                         o_dbg_mesi,
  output logic [CNT_W-1:0]                   o_stat_hits,
  output logic [CNT_W-1:0]                   o_stat_misses
);
  localparam int TAG_W  = ADDR_W - OFFSET_W - SET_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int SETS   = 2 ** SET_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_e            r_state, w_next_state;
  logic [2:0]        r_cmd;
  logic [LINE_W-1:0] r_line;
  logic              r_hit;
  logic [WAY_W-1:0]  r_way;
  logic [SET_W-1:0]  r_clr_set;
  logic [CNT_W-1:0]  r_hits, r_misses;
  logic [TAG_W-1:0]  r_tag  [SETS][WAYS];
  mesi_e             r_mesi [SETS][WAYS];
  logic [WAYS-2:0]   r_plru [SETS];

  logic [SET_W-1:0]  w_set;
  logic [TAG_W-1:0]  w_req_tag;
  logic              w_hit, w_any_inv, w_victim_dirty;
  logic [WAY_W-1:0]  w_hit_way, w_first_inv, w_plru_victim, w_victim_way, w_access_way;
  mesi_e             w_hit_mesi;
  logic [WAYS-2:0]   w_plru_next;
  logic              w_accept, w_line_we, w_tag_we, w_plru_we, w_clr;
  logic [WAY_W-1:0]  w_line_way;
  mesi_e             w_line_mesi;

  assign w_set     = r_line[SET_W-1:0];
  assign w_req_tag = r_line[LINE_W-1:SET_W];

  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_any_inv   = 1'b0;
    w_first_inv = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_mesi[w_set][w] == MESI_I) begin
        w_any_inv   = 1'b1;
        w_first_inv = WAY_W'(w);
      end else if (r_tag[w_set][w] == w_req_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_victim_way   = w_any_inv ? w_first_inv : w_plru_victim;
  assign w_victim_dirty = (r_mesi[w_set][w_victim_way] == MESI_M);
  assign w_hit_mesi     = r_mesi[w_set][w_hit_way];
  assign w_access_way   = (r_state == S_FILL) ? r_way : w_hit_way;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits       (r_plru[w_set]),
    .i_access_way (w_access_way),
    .o_victim     (w_plru_victim),
    .o_bits_next  (w_plru_next)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_line_we      = 1'b0;
    w_tag_we       = 1'b0;
    w_line_way     = r_way;
    w_line_mesi    = MESI_I;
    w_plru_we      = 1'b0;
    w_clr          = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_hit   = 1'b0;
    bus.l2_valid   = 1'b0;
    bus.l2_cmd     = L2_RETURNDATA;
    bus.l2_addr    = '0;
    unique case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = (bus.cmd == CMD_CLEAR) ? S_CLEAR : S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        w_next_state = S_RESP;
        w_line_way   = w_hit_way;
        case (r_cmd)
          CMD_READ: begin
            if (w_hit) w_plru_we = 1'b1;
            else       w_next_state = w_victim_dirty ? S_EVICT : S_FILL;
          end
          CMD_WRITE: begin
            if (!w_hit) begin
              w_next_state = w_victim_dirty ? S_EVICT : S_FILL;
            end else if (w_hit_mesi == MESI_S) begin
              w_next_state = S_FILL;
            end else begin
              w_line_we   = 1'b1;
              w_line_mesi = MESI_M;
              w_plru_we   = 1'b1;
            end
          end
          CMD_INVALIDATE: begin
            if (w_hit && w_hit_mesi == MESI_M) w_next_state = S_FILL;
            else if (w_hit)                    w_line_we    = 1'b1;
          end
          CMD_DATAREQ: begin
            if (w_hit && w_hit_mesi == MESI_M) begin
              w_next_state = S_FILL;
            end else if (w_hit && w_hit_mesi == MESI_E) begin
              w_line_we   = 1'b1;
              w_line_mesi = MESI_S;
            end
          end
          default: ;
        endcase
      end
      S_EVICT: begin
        bus.l2_valid = 1'b1;
        bus.l2_cmd   = L2_WRITE;
        bus.l2_addr  = {r_tag[w_set][r_way], w_set, {OFFSET_W{1'b0}}};
        w_next_state = S_FILL;
      end
      S_FILL: begin
        bus.l2_valid = 1'b1;
        bus.l2_addr  = {r_line, {OFFSET_W{1'b0}}};
        w_line_we    = 1'b1;
        w_next_state = S_RESP;
        case (r_cmd)
          CMD_READ: begin
            bus.l2_cmd  = L2_READ;
            w_tag_we    = 1'b1;
            w_line_mesi = MESI_E;
            w_plru_we   = 1'b1;
          end
          CMD_WRITE: begin
            bus.l2_cmd  = L2_RFO;
            w_tag_we    = 1'b1;
            w_line_mesi = MESI_M;
            w_plru_we   = 1'b1;
          end
          CMD_INVALIDATE: bus.l2_cmd = L2_WRITE;
          default: begin
            bus.l2_cmd  = L2_RETURNDATA;
            w_line_mesi = MESI_S;
          end
        endcase
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_hit   = r_hit;
        w_next_state   = S_IDLE;
      end
      S_CLEAR: begin
        w_clr = 1'b1;
        if (&r_clr_set) w_next_state = S_RESP;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: the tag/MESI/PLRU arrays are flops with a defined reset image, so they reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_line    <= '0;
      r_hit     <= 1'b0;
      r_way     <= '0;
      r_clr_set <= '0;
      r_hits    <= '0;
      r_misses  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w]  <= '0;
          r_mesi[s][w] <= MESI_I;
        end
      end
    end else begin
      if (w_accept) begin
        r_cmd     <= bus.cmd;
        r_line    <= bus.addr[ADDR_W-1:OFFSET_W];
        r_hit     <= 1'b0;
        r_clr_set <= '0;
      end
      if (r_state == S_LOOKUP) begin
        r_hit <= w_hit && (r_cmd <= CMD_DATAREQ);
        r_way <= w_hit ? w_hit_way : w_victim_way;
        if (r_cmd == CMD_READ || r_cmd == CMD_WRITE) begin
          if (w_hit) begin
            if (!(&r_hits)) r_hits <= r_hits + CNT_W'(1);
          end else if (!(&r_misses)) begin
            r_misses <= r_misses + CNT_W'(1);
          end
        end
      end
      if (w_line_we) begin
        r_mesi[w_set][w_line_way] <= w_line_mesi;
        if (w_tag_we) r_tag[w_set][w_line_way] <= w_req_tag;
      end
      if (w_plru_we) r_plru[w_set] <= w_plru_next;
      if (w_clr) begin
        for (int w = 0; w < WAYS; w++) r_mesi[r_clr_set][w] <= MESI_I;
        r_plru[r_clr_set] <= '0;
        r_hits            <= '0;
        r_misses          <= '0;
        r_clr_set         <= r_clr_set + SET_W'(1);
      end
    end
  end

  assign o_dbg_tag     = r_tag[i_dbg_set][i_dbg_way];
  assign o_dbg_mesi    = r_mesi[i_dbg_set][i_dbg_way];
  assign o_stat_hits   = r_hits;
  assign o_stat_misses = r_misses;

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed bench for mesi_cache_ctrl: stimulus pushes expected responses and
// L2 messages into queues, a negedge monitor pops and compares them.
module tb_mesi_cache_ctrl;
  import cache_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LAT_MAX = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  dbg_set;
  logic [1:0]  dbg_way;
  logic [21:0] dbg_tag;
  logic [1:0]  dbg_mesi;
  logic [31:0] stat_hits, stat_misses;

  always #5 clk = ~clk;

  mesi_cache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mesi_cache_ctrl #(
    .ADDR_W(ADDR_W), .OFFSET_W(6), .SET_W(4), .WAYS(4), .CNT_W(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .i_dbg_set     (dbg_set),
    .i_dbg_way     (dbg_way),
    .o_dbg_tag     (dbg_tag),
    .o_dbg_mesi    (dbg_mesi),
    .o_stat_hits   (stat_hits),
    .o_stat_misses (stat_misses)
  );

  int          checks = 0;
  int          failures = 0;
  int          resp_cnt = 0;
  logic        exp_resp_q[$];
  logic [33:0] exp_l2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response / L2 strobe must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) begin
        resp_cnt++;
        check("resp_pending", 64'(exp_resp_q.size() != 0), 64'd1);
        if (exp_resp_q.size() != 0) check("resp_hit", 64'(bus.resp_hit), 64'(exp_resp_q.pop_front()));
      end
      if (bus.l2_valid) begin
        check("l2_pending", 64'(exp_l2_q.size() != 0), 64'd1);
        if (exp_l2_q.size() != 0) check("l2_msg", 64'({bus.l2_cmd, bus.l2_addr}), 64'(exp_l2_q.pop_front()));
      end
    end
  end

  task automatic expect_l2(input logic [1:0] c, input logic [31:0] a);
    exp_l2_q.push_back({c, a});
  endtask

  task automatic expect_resp(input logic h);
    exp_resp_q.push_back(h);
  endtask

  // Issue one command from IDLE; lat = negedges after the accepting edge until resp_valid.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, output int lat);
    int start;
    @(negedge clk);
    check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    bus.cmd = c;
    bus.addr = a;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    start = resp_cnt;
    lat = 0;
    while (resp_cnt == start && lat < LAT_MAX) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("resp_arrived", 64'(resp_cnt != start), 64'd1);
    check("l2_drained", 64'(exp_l2_q.size()), 64'd0);
  endtask

  task automatic dbg_check(input string name, input int s, input int w,
                           input logic [21:0] tag, input logic [1:0] mesi);
    dbg_set = 4'(s);
    dbg_way = 2'(w);
    #1;
    check({name, "_tag"}, 64'(dbg_tag), 64'(tag));
    check({name, "_mesi"}, 64'(dbg_mesi), 64'(mesi));
  endtask

  task automatic stat_check(input string name, input int h, input int m);
    check({name, "_hits"}, 64'(stat_hits), 64'(h));
    check({name, "_misses"}, 64'(stat_misses), 64'(m));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int non_i;
    int saved;
    int wait_n;
    bus.cmd_valid = 1'b0;
    bus.cmd = '0;
    bus.addr = '0;
    dbg_set = '0;
    dbg_way = '0;

    // Reset image
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_l2_valid", 64'(bus.l2_valid), 64'd0);
    check("rst_l2_cmd", 64'(bus.l2_cmd), 64'd0);
    check("rst_l2_addr", 64'(bus.l2_addr), 64'd0);
    stat_check("rst", 0, 0);
    dbg_check("rst_s1w0", 1, 0, 22'd0, MESI_I);
    rst_n = 1'b1;

    // Miss then hit on 0x1040
    expect_l2(L2_READ, 32'h1040);
    expect_resp(1'b0);
    issue(CMD_READ, 32'h1040, lat);
    check("read_miss_latency", 64'(lat), 64'd3);
    dbg_check("fill_s1w0", 1, 0, 22'd4, MESI_E);
    expect_resp(1'b1);
    issue(CMD_READ, 32'h1040, lat);
    check("read_hit_latency", 64'(lat), 64'd2);
    stat_check("after_hit", 1, 1);

    // CLEAR wipes validity, PLRU and counters
    expect_resp(1'b0);
    issue(CMD_CLEAR, 32'h0, lat);
    check("clear_latency_in_range", 64'(lat >= 17 && lat <= 18), 64'd1);
    stat_check("after_clear", 0, 0);
    non_i = 0;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 4; w++) begin
        dbg_set = 4'(s);
        dbg_way = 2'(w);
        #1;
        if (dbg_mesi != MESI_I) non_i++;
      end
    end
    check("clear_all_invalid", 64'(non_i), 64'd0);

    // Fill set 1, touch every way, then force a PLRU eviction of the dirty way 0
    expect_l2(L2_READ, 32'h0440); expect_resp(1'b0); issue(CMD_READ, 32'h0440, lat);
    expect_l2(L2_READ, 32'h0840); expect_resp(1'b0); issue(CMD_READ, 32'h0840, lat);
    expect_l2(L2_READ, 32'h0C40); expect_resp(1'b0); issue(CMD_READ, 32'h0C40, lat);
    expect_l2(L2_READ, 32'h1040); expect_resp(1'b0); issue(CMD_READ, 32'h1040, lat);
    expect_resp(1'b1); issue(CMD_WRITE, 32'h0440, lat);
    dbg_check("write_hit_s1w0", 1, 0, 22'd1, MESI_M);
    expect_resp(1'b1); issue(CMD_READ, 32'h0840, lat);
    expect_resp(1'b1); issue(CMD_READ, 32'h0C40, lat);
    expect_resp(1'b1); issue(CMD_READ, 32'h1040, lat);
    expect_l2(L2_WRITE, 32'h0440);
    expect_l2(L2_READ, 32'h1440);
    expect_resp(1'b0);
    issue(CMD_READ, 32'h1440, lat);
    check("evict_latency", 64'(lat), 64'd4);
    dbg_check("evict_s1w0", 1, 0, 22'd5, MESI_E);
    dbg_check("keep_s1w3", 1, 3, 22'd4, MESI_E);
    stat_check("after_evict", 4, 5);

    // Write miss, snoop read of a modified line, upgrade from S
    expect_l2(L2_RFO, 32'h2000); expect_resp(1'b0); issue(CMD_WRITE, 32'h2000, lat);
    dbg_check("rfo_s0w0", 0, 0, 22'd8, MESI_M);
    expect_l2(L2_RETURNDATA, 32'h2000); expect_resp(1'b1); issue(CMD_DATAREQ, 32'h2000, lat);
    dbg_check("datareq_s0w0", 0, 0, 22'd8, MESI_S);
    expect_l2(L2_RFO, 32'h2000); expect_resp(1'b1); issue(CMD_WRITE, 32'h2000, lat);
    dbg_check("upgrade_s0w0", 0, 0, 22'd8, MESI_M);
    stat_check("after_upgrade", 5, 6);

    // Invalidate a modified line, refetch, snoop misses and an undefined code
    expect_l2(L2_RFO, 32'h3000); expect_resp(1'b0); issue(CMD_WRITE, 32'h3000, lat);
    dbg_check("m_s0w1", 0, 1, 22'd12, MESI_M);
    expect_l2(L2_WRITE, 32'h3000); expect_resp(1'b1); issue(CMD_INVALIDATE, 32'h3000, lat);
    dbg_check("inval_s0w1", 0, 1, 22'd12, MESI_I);
    expect_l2(L2_READ, 32'h3000); expect_resp(1'b0); issue(CMD_READ, 32'h3000, lat);
    expect_resp(1'b0); issue(CMD_INVALIDATE, 32'h5000, lat);
    expect_resp(1'b1); issue(CMD_DATAREQ, 32'h3000, lat);
    dbg_check("e_to_s_s0w1", 0, 1, 22'd12, MESI_S);
    expect_resp(1'b0); issue(3'd5, 32'h3000, lat);
    check("code5_latency", 64'(lat), 64'd2);
    dbg_check("code5_s0w1", 0, 1, 22'd12, MESI_S);
    stat_check("after_snoops", 5, 8);

    // Reset while the dirty victim is being written back
    expect_l2(L2_RFO, 32'h0480); expect_resp(1'b0); issue(CMD_WRITE, 32'h0480, lat);
    expect_l2(L2_READ, 32'h0880); expect_resp(1'b0); issue(CMD_READ, 32'h0880, lat);
    expect_l2(L2_READ, 32'h0C80); expect_resp(1'b0); issue(CMD_READ, 32'h0C80, lat);
    expect_l2(L2_READ, 32'h1080); expect_resp(1'b0); issue(CMD_READ, 32'h1080, lat);
    expect_l2(L2_WRITE, 32'h0480);
    @(negedge clk);
    bus.cmd = CMD_READ;
    bus.addr = 32'h1480;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_n = 0;
    while (exp_l2_q.size() != 0 && wait_n < 20) begin
      @(negedge clk);
      #1;
      wait_n++;
    end
    check("evict_before_reset", 64'(exp_l2_q.size()), 64'd0);
    check("evict_strobe_live", 64'(bus.l2_valid), 64'd1);
    saved = resp_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_l2_valid", 64'(bus.l2_valid), 64'd0);
    check("abort_l2_cmd", 64'(bus.l2_cmd), 64'd0);
    check("abort_l2_addr", 64'(bus.l2_addr), 64'd0);
    check("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_resp", 64'(resp_cnt), 64'(saved));
    check("ready_after_release", 64'(bus.cmd_ready), 64'd1);
    dbg_check("abort_s2w0", 2, 0, 22'd0, MESI_I);
    stat_check("abort", 0, 0);
    expect_l2(L2_READ, 32'h0480); expect_resp(1'b0); issue(CMD_READ, 32'h0480, lat);
    stat_check("post_abort", 0, 1);

    repeat (4) @(negedge clk);
    check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
    check("l2_queue_empty", 64'(exp_l2_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
